// File: rtl/cnn_pkg.sv
// Shared constants and encodings for the CNN display path:
// output-buffer geometry, scan states and read-return tags.
package cnn_pkg;
  localparam int H_ACT    = 480;
  localparam int V_ACT    = 272;
  localparam int DEPTH    = H_ACT * V_ACT;
  localparam int ADDR_W   = 17;
  localparam int RGB565_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scanState_t;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_LCD     = 2'd1,
    TAG_DBG     = 2'd2,
    TAG_DBG_OOR = 2'd3
  } rdTag_t;

  // One in-flight return: who gets the data, and whether LCD data is forced black.
  typedef struct packed {
    rdTag_t tag;
    logic   blank;
  } retSlot_t;
endpackage

// File: rtl/obuf_scan_addr_gen.sv
// Raster scan address for LCD fetches: wraps at DEPTH-1 with a frame-end
// pulse, and can be realigned to 0 by vsync.
module obuf_scan_addr_gen #(
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DEPTH  = cnn_pkg::DEPTH
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClr,
  input  logic              iVSync,
  input  logic              iAdv,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oFrameEnd
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cntQ, cntNext;

  // A vsync in the same cycle as a fetch makes that fetch read address 0.
  assign oAddr     = iVSync ? '0 : cntQ;
  assign oFrameEnd = iAdv && (oAddr == LAST);

  always_comb begin
    cntNext = cntQ;
    if (iClr)        cntNext = '0;
    else if (iAdv)   cntNext = (oAddr == LAST) ? '0 : oAddr + 1'b1;
    else if (iVSync) cntNext = '0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) cntQ <= '0;
    else      cntQ <= cntNext;
  end
endmodule

// File: rtl/obuf_read_scheduler.sv
// Single read port arbiter for the RGB565 output buffer: LCD scan-out has
// priority, idle cycles go to the debug requester; returns arrive 1 cycle later.
module obuf_read_scheduler
  import cnn_pkg::*;
#(
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DATA_W = cnn_pkg::RGB565_W,
  parameter int H_ACT  = cnn_pkg::H_ACT,
  parameter int V_ACT  = cnn_pkg::V_ACT,
  parameter int DEPTH  = H_ACT * V_ACT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFrameDone,
  input  logic              iLcdVSync,
  input  logic              iLcdReq,
  output logic              oLcdValid,
  output logic [DATA_W-1:0] oLcdData,
  input  logic              iDbgReq,
  input  logic [ADDR_W-1:0] iDbgAddr,
  output logic              oDbgGnt,
  output logic              oDbgValid,
  output logic [DATA_W-1:0] oDbgData,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [DATA_W-1:0] iRdData,
  output logic              oScanActive,
  output logic              oFrameEnd
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  scanState_t        stateQ, stateNext;
  retSlot_t          retQ, retNext;
  logic [DATA_W-1:0] lcdHoldQ, dbgHoldQ;
  logic [ADDR_W-1:0] scanAddr;
  logic              scanning, lcdRd, dbgWin, dbgInRange;

  assign scanning   = (stateQ == ST_SCAN);
  assign lcdRd      = !iRst && scanning && iLcdReq;
  // An IDLE LCD strobe still owns next cycle's return slot, so debug waits.
  assign dbgWin     = !iRst && iDbgReq && !iLcdReq;
  assign dbgInRange = (iDbgAddr < DEPTH_A);

  obuf_scan_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) uScanAddr (
    .iClk     (iClk),
    .iRst     (iRst),
    .iClr     (!scanning && iFrameDone),
    .iVSync   (scanning && iLcdVSync),
    .iAdv     (lcdRd),
    .oAddr    (scanAddr),
    .oFrameEnd(oFrameEnd)
  );

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      ST_IDLE: if (iFrameDone) stateNext = ST_SCAN;
      ST_SCAN: stateNext = ST_SCAN;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    retNext = '{tag: TAG_NONE, blank: 1'b0};
    if (iLcdReq)      retNext = '{tag: TAG_LCD, blank: !scanning};
    else if (iDbgReq) retNext = '{tag: dbgInRange ? TAG_DBG : TAG_DBG_OOR, blank: 1'b0};
  end

  always_comb begin
    oRdEn   = lcdRd || (dbgWin && dbgInRange);
    oRdAddr = '0;
    if (lcdRd)      oRdAddr = scanAddr;
    else if (oRdEn) oRdAddr = iDbgAddr;
  end

  assign oDbgGnt     = dbgWin;
  assign oScanActive = !iRst && scanning;

  // Return path: valids are masked during reset so an in-flight read is dropped.
  assign oLcdValid = !iRst && (retQ.tag == TAG_LCD);
  assign oDbgValid = !iRst && ((retQ.tag == TAG_DBG) || (retQ.tag == TAG_DBG_OOR));
  assign oLcdData  = oLcdValid ? (retQ.blank ? '0 : iRdData) : lcdHoldQ;
  assign oDbgData  = oDbgValid ? ((retQ.tag == TAG_DBG) ? iRdData : '0) : dbgHoldQ;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ   <= ST_IDLE;
      retQ     <= '{tag: TAG_NONE, blank: 1'b0};
      lcdHoldQ <= '0;
      dbgHoldQ <= '0;
    end else begin
      stateQ   <= stateNext;
      retQ     <= retNext;
      lcdHoldQ <= oLcdData;
      dbgHoldQ <= oDbgData;
    end
  end
endmodule

// File: tb/tb_obuf_read_scheduler.sv
// Scoreboard bench for obuf_read_scheduler: a frame-level reference model
// predicts port activity and queues expected returns for a separate monitor.
module tb_obuf_read_scheduler;
  localparam int DEPTH = 130560;

  logic        iClk, iRst, iFrameDone, iLcdVSync, iLcdReq, iDbgReq;
  logic [16:0] iDbgAddr;
  logic        oLcdValid, oDbgGnt, oDbgValid, oRdEn, oScanActive, oFrameEnd;
  logic [15:0] oLcdData, oDbgData, iRdData;
  logic [16:0] oRdAddr;
  logic [16:0] forceVal;

  obuf_read_scheduler dut (
    .iClk(iClk), .iRst(iRst), .iFrameDone(iFrameDone), .iLcdVSync(iLcdVSync),
    .iLcdReq(iLcdReq), .oLcdValid(oLcdValid), .oLcdData(oLcdData),
    .iDbgReq(iDbgReq), .iDbgAddr(iDbgAddr), .oDbgGnt(oDbgGnt),
    .oDbgValid(oDbgValid), .oDbgData(oDbgData), .oRdEn(oRdEn),
    .oRdAddr(oRdAddr), .iRdData(iRdData), .oScanActive(oScanActive),
    .oFrameEnd(oFrameEnd)
  );

  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end

  function automatic logic [15:0] ramVal(int a);
    return a[15:0];
  endfunction

  // Buffer contents are RAM[i] = i; junk on idle cycles exposes bogus captures.
  always @(posedge iClk) iRdData <= oRdEn ? ramVal(int'(oRdAddr)) : 16'hDEAD;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int nChk = 0, nFail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t lcdQ[$];
  exp_t dbgQ[$];

  // Monitor: every presented valid must match the oldest expectation due now.
  always @(negedge iClk) begin
    exp_t e;
    if (oLcdValid) begin
      if (lcdQ.size() == 0 || lcdQ[0].due != cyc) chk("lcd_valid_unexpected", 32'(oLcdValid), 0);
      else begin e = lcdQ.pop_front(); chk("lcd_data", 32'(oLcdData), 32'(e.data)); end
    end else if (lcdQ.size() != 0 && lcdQ[0].due == cyc) begin
      chk("lcd_valid_missing", 32'(oLcdValid), 1);
      void'(lcdQ.pop_front());
    end
    if (oDbgValid) begin
      if (dbgQ.size() == 0 || dbgQ[0].due != cyc) chk("dbg_valid_unexpected", 32'(oDbgValid), 0);
      else begin e = dbgQ.pop_front(); chk("dbg_data", 32'(oDbgData), 32'(e.data)); end
    end else if (dbgQ.size() != 0 && dbgQ[0].due == cyc) begin
      chk("dbg_valid_missing", 32'(oDbgValid), 1);
      void'(dbgQ.pop_front());
    end
  end

  // Reference model: whether a frame is available and the next raster pixel.
  bit scanM = 0;
  int addrM = 0;

  task automatic step(bit lcd, bit vs, bit fd, bit dbg, logic [16:0] da, bit rst);
    int  eff, expAddr;
    bit  lcdRd, gnt, inr, expEn, expFe, expScan;
    iLcdReq = lcd; iLcdVSync = vs; iFrameDone = fd;
    iDbgReq = dbg; iDbgAddr = da; iRst = rst;
    if (rst) begin lcdQ.delete(); dbgQ.delete(); end
    @(negedge iClk);
    eff     = (scanM && vs) ? 0 : addrM;
    lcdRd   = !rst && scanM && lcd;
    gnt     = !rst && dbg && !lcd;
    inr     = int'(da) < DEPTH;
    expEn   = lcdRd || (gnt && inr);
    expAddr = lcdRd ? eff : int'(da);
    expFe   = lcdRd && (eff == DEPTH - 1);
    expScan = !rst && scanM;
    chk("rd_en", 32'(oRdEn), 32'(expEn));
    if (expEn) chk("rd_addr", 32'(oRdAddr), expAddr);
    chk("dbg_gnt", 32'(oDbgGnt), 32'(gnt));
    chk("frame_end", 32'(oFrameEnd), 32'(expFe));
    chk("scan_active", 32'(oScanActive), 32'(expScan));
    if (!rst) begin
      if (lcd)      lcdQ.push_back('{cyc + 1, scanM ? ramVal(eff) : 16'h0000});
      else if (gnt) dbgQ.push_back('{cyc + 1, inr ? ramVal(int'(da)) : 16'h0000});
      if (lcdRd)      addrM = (eff + 1) % DEPTH;
      else if (scanM) addrM = eff;
      if (!scanM && fd) begin scanM = 1; addrM = 0; end
    end else begin
      scanM = 0; addrM = 0;
    end
    @(posedge iClk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic lcdPix(int gap);
    step(1, 0, 0, 0, '0, 0);
    idle(gap);
  endtask

  task automatic forceScan(int v);
    forceVal = 17'(v);
    force dut.uScanAddr.cntQ = forceVal;
    idle(2);
    release dut.uScanAddr.cntQ;
    addrM = v;
  endtask

  initial begin
    iRst = 1; iFrameDone = 0; iLcdVSync = 0; iLcdReq = 0; iDbgReq = 0; iDbgAddr = '0;
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
    @(negedge iClk);
    chk("rst_lcd_valid", 32'(oLcdValid), 0);
    chk("rst_dbg_valid", 32'(oDbgValid), 0);
    chk("rst_lcd_data", 32'(oLcdData), 0);
    chk("rst_dbg_data", 32'(oDbgData), 0);
    @(posedge iClk); #1;

    // Black pixels before any frame exists.
    for (int i = 0; i < 5; i++) lcdPix(3);

    // First frame, strobes every 16 clocks.
    step(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < 20; i++) lcdPix(15);

    // Wrap at the last scan address.
    forceScan(130558);
    for (int i = 0; i < 3; i++) lcdPix(15);

    // Vsync realign together with a fetch.
    forceScan(1000);
    step(1, 1, 0, 0, '0, 0);
    idle(15);
    lcdPix(15);

    // Debug loses to LCD, then is granted; then an out-of-range address.
    step(1, 0, 0, 1, 17'h00123, 0);
    step(0, 0, 0, 1, 17'h00123, 0);
    idle(2);
    step(0, 0, 0, 1, 17'(DEPTH), 0);
    idle(2);

    // Reset right behind an LCD read drops the return and re-arms IDLE.
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 1);
    idle(2);
    lcdPix(3);
    lcdPix(3);

    // Randomized traffic mixing all inputs.
    step(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [16:0] da;
      da = ($urandom_range(3) == 0) ? 17'($urandom_range(131071, DEPTH))
                                    : 17'($urandom_range(DEPTH - 1, 0));
      step($urandom_range(3) == 0, $urandom_range(19) == 0, $urandom_range(49) == 0,
           $urandom_range(2) == 0, da, $urandom_range(299) == 0);
    end
    idle(3);

    chk("lcd_queue_drained", 32'(lcdQ.size()), 0);
    chk("dbg_queue_drained", 32'(dbgQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
